online_dct_seq: RTL and testbench
=================================

Name: online_dct_seq

Overview:
- Sequencer in front of the 4-tap online DCT datapath (x window x_reg1..x_reg4 → CCMs → online adder tree → data_out_reg).
- The datapath clears its whole window whenever its enable is low, so it cannot be stalled. This block therefore buffers a complete frame from a valid/ready source first.
- It then streams the frame with enable held high for back-to-back cycles, appends one flush cycle, and captures exactly the full-window results as a qualified output stream.

Parameters:
- STAGE, 8, online digit count of datapath; sample width WL=2*STAGE, result width WLY=2*(STAGE+5)
- FRAME_LEN, 8, samples per frame; legal range 4..256
- CW, 9, counter width; must satisfy 2^CW > FRAME_LEN+2

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- soft_clr  in  1  synchronous abort; discards current frame
- in_data  in  WL  input sample (redundant online digits, passed unchanged)
- in_valid  in  1  source has sample
- in_ready  out  1  block accepts sample this cycle
- dct_enable  out  1  drives datapath enable
- dct_din  out  WL  drives datapath din_x
- dct_dout  in  WLY  datapath data_out
- out_data  out  WLY  registered result
- out_valid  out  1  out_data holds a full-window result (no backpressure)
- frame_done  out  1  one-cycle pulse after the last result of a frame
- busy  out  1  high in RUN/FLUSH/TAIL
- frame_cnt  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (nrst=0 at a clk edge) sets: state=LOAD, wr_ptr=0, rd_ptr=0, in_ready=0 for that cycle, then 1 in LOAD; dct_enable=0, dct_din=0, out_data=0, out_valid=0, frame_done=0, frame_cnt=0. Buffer contents are don't-care.
- Buffer: FRAME_LEN x WL register array, written in LOAD only, read in RUN only. There is no concurrent read and write.
- LOAD:
  - in_ready=1, dct_enable=0, dct_din=0.
  - A transfer occurs when in_valid&in_ready; it writes buf[wr_ptr] and increments wr_ptr.
  - On the transfer that brings the count to FRAME_LEN: next state is RUN, wr_ptr=0, and in_ready drops in the next cycle (registered).
- RUN:
  - Lasts FRAME_LEN cycles, r=0..FRAME_LEN-1. dct_enable=1, dct_din=buf[r] (registered output, rd_ptr pre-fetched), in_ready=0.
  - After cycle FRAME_LEN-1 the state goes to FLUSH.
- FLUSH: one cycle; dct_enable=1, dct_din=0. Next state is TAIL.
- TAIL: one cycle; dct_enable=0 and dct_din=0 (the datapath window clears at the end edge). Next state is LOAD.
- Result timing, with RUN cycle 0 as reference:
  - dct_dout for the window ending at sample j (s_j..s_{j-3}) is present in cycle j+2.
  - The block registers dct_dout into out_data at that cycle's edge, with out_valid=1 in cycle j+3.
- Valid windows: only j=3..FRAME_LEN-1, which gives FRAME_LEN-3 results per frame.
  - out_valid is high in cycles 6..FRAME_LEN+2 inclusive, contiguous.
  - The partial windows j=0..2 (zero-padded from the cleared window) are never flagged valid.
- frame_done: high in cycle FRAME_LEN+2, coincident with the last out_valid. frame_cnt increments at that same edge.
- out_data holds its last value when out_valid=0 (not zeroed).
- Overlap: the first LOAD cycle of the next frame is cycle FRAME_LEN+2, so the last result may coincide with a new input transfer. Both are legal.
- soft_clr (lower priority than nrst), sampled at an edge in any state, forces:
  - state=LOAD, pointers=0, dct_enable=0, out_valid=0, frame_done=0;
  - partial frame discarded; frame_cnt unchanged;
  - any in_valid transfer in the same cycle is dropped.
- Reset mid-frame behaves like soft_clr and also zeroes frame_cnt.
- in_valid low during LOAD simply waits; there is no timeout.
- Width rules: data is never modified by this block. dct_din and out_data are bit-exact copies of buffered and datapath values.

Test Plan:
- Reset: nrst=0 for 3 cycles with in_valid=1 → in_ready=0, dct_enable=0, out_valid=0, frame_cnt=0. The first transfer occurs in the 1st cycle after nrst rises.
- Single frame, FRAME_LEN=8, samples 0x0101..0x0808 sent back-to-back:
  - dct_enable high for exactly 9 cycles, with dct_din = 0x0101..0x0808 then 0x0000;
  - out_valid high for 5 cycles, starting 6 cycles after the first RUN cycle;
  - out_data equals the datapath model for windows j=3..7;
  - frame_done pulses once; frame_cnt=1.
- Gapped input: in_valid toggled 1/0 during LOAD → same RUN sequence as back-to-back input, with no gaps in dct_enable.
- Back-to-back frames: 3 frames with in_valid held high → 15 valid results in total; frame_cnt=3. A new LOAD transfer coincides with the last out_valid of each frame without loss.
- soft_clr during RUN cycle r=4:
  - dct_enable falls next cycle; no further out_valid;
  - frame_cnt unchanged;
  - the next full 8-sample frame produces a correct 5-result output.
- FRAME_LEN=4 build → exactly 1 result per frame, at cycle 6 after RUN start.

Source files
------------

// File: rtl/online_dct_seq.sv
`timescale 1ns/1ps
// Frame sequencer for the 4-tap online DCT: buffers FRAME_LEN samples, streams them with enable held high plus one flush cycle.
// Results registered one cycle after the datapath; source is stalled (in_ready=0) outside LOAD; the output stream has no backpressure.
module online_dct_seq #(
  parameter int STAGE     = 8,
  parameter int FRAME_LEN = 8,
  parameter int CW        = 9
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      soft_clr,
  input  logic [2*STAGE-1:0]        in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      dct_enable,
  output logic [2*STAGE-1:0]        dct_din,
  input  logic [2*(STAGE+5)-1:0]    dct_dout,
  output logic [2*(STAGE+5)-1:0]    out_data,
  output logic                      out_valid,
  output logic                      frame_done,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);

  localparam int WL = 2*STAGE;
  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST     = CW'(FRAME_LEN-1);
  localparam logic [CW-1:0] FIRST_OK = CW'(5);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_FLUSH, S_TAIL} state_t;

  state_t          state;
  logic [WL-1:0]   frame_buf [FRAME_LEN];
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   cyc;
  logic            xfer;
  logic            capture;

  assign xfer = in_valid & in_ready;
  // cyc counts from RUN cycle 0; datapath output for window j appears in cycle j+2, first full window is j=3
  assign capture = (state != S_LOAD) && (cyc >= FIRST_OK);
  assign busy = (state != S_LOAD);

  always_ff @(posedge clk) begin
    if (nrst && !soft_clr && xfer) begin
      frame_buf[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cyc        <= '0;
      in_ready   <= 1'b0;
      dct_enable <= 1'b0;
      dct_din    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else if (soft_clr) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cyc        <= '0;
      in_ready   <= 1'b1;
      dct_enable <= 1'b0;
      dct_din    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= capture;
      frame_done <= (state == S_TAIL);
      if (capture) begin
        out_data <= dct_dout;
      end
      if (state == S_TAIL) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      case (state)
        S_LOAD: begin
          in_ready <= 1'b1;
          if (xfer) begin
            if (wr_ptr == LAST) begin
              // sample 0 is prefetched so RUN starts streaming on its first cycle
              state      <= S_RUN;
              wr_ptr     <= '0;
              in_ready   <= 1'b0;
              dct_enable <= 1'b1;
              dct_din    <= frame_buf[0];
              rd_ptr     <= CW'(1);
              cyc        <= '0;
            end else begin
              wr_ptr <= wr_ptr + CW'(1);
            end
          end
        end
        S_RUN: begin
          cyc <= cyc + CW'(1);
          if (cyc == LAST) begin
            state   <= S_FLUSH;
            dct_din <= '0;
            rd_ptr  <= '0;
          end else begin
            dct_din <= frame_buf[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + CW'(1);
          end
        end
        S_FLUSH: begin
          cyc        <= cyc + CW'(1);
          state      <= S_TAIL;
          dct_enable <= 1'b0;
          dct_din    <= '0;
        end
        S_TAIL: begin
          state    <= S_LOAD;
          cyc      <= '0;
          in_ready <= 1'b1;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_online_dct_seq.sv
`timescale 1ns/1ps
// Bench for online_dct_seq: a behavioural 4-tap window datapath stub feeds dct_dout; results checked against window sums.
module tb_online_dct_seq;

  localparam int STAGE = 8;
  localparam int N     = 8;
  localparam int WL    = 2*STAGE;
  localparam int WLY   = 2*(STAGE+5);

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic soft_clr = 1'b0;
  logic [WL-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, dct_enable, out_valid, frame_done, busy;
  logic [WL-1:0] dct_din;
  logic [WLY-1:0] dct_dout = '0;
  logic [WLY-1:0] out_data;
  logic [15:0] frame_cnt;

  logic [WL-1:0] in_data_4 = '0;
  logic in_valid_4 = 1'b0;
  logic in_ready_4, dct_enable_4, out_valid_4, frame_done_4, busy_4;
  logic [WL-1:0] dct_din_4;
  logic [WLY-1:0] dct_dout_4 = '0;
  logic [WLY-1:0] out_data_4;
  logic [15:0] frame_cnt_4;

  int n_chk = 0;
  int n_fail = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  online_dct_seq #(.STAGE(STAGE), .FRAME_LEN(N), .CW(9)) u_dut (
    .clk(clk), .nrst(nrst), .soft_clr(soft_clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dct_enable(dct_enable), .dct_din(dct_din), .dct_dout(dct_dout),
    .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done), .busy(busy),
    .frame_cnt(frame_cnt));

  online_dct_seq #(.STAGE(STAGE), .FRAME_LEN(4), .CW(9)) u_dut4 (
    .clk(clk), .nrst(nrst), .soft_clr(1'b0), .in_data(in_data_4), .in_valid(in_valid_4),
    .in_ready(in_ready_4), .dct_enable(dct_enable_4), .dct_din(dct_din_4), .dct_dout(dct_dout_4),
    .out_data(out_data_4), .out_valid(out_valid_4), .frame_done(frame_done_4), .busy(busy_4),
    .frame_cnt(frame_cnt_4));

  function automatic logic [WLY-1:0] win_f(input logic [WL-1:0] a, b, c, d);
    return WLY'(a) * WLY'(3) + WLY'(b) * WLY'(5) + WLY'(c) * WLY'(7) + WLY'(d) * WLY'(11);
  endfunction

  // datapath stand-in: window clears when enable is low, output lags the window by one register
  logic [WL-1:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic [WL-1:0] y1 = '0, y2 = '0, y3 = '0, y4 = '0;
  always @(posedge clk) begin
    dct_dout   <= win_f(x1, x2, x3, x4);
    dct_dout_4 <= win_f(y1, y2, y3, y4);
    if (!dct_enable) begin x1 <= '0; x2 <= '0; x3 <= '0; x4 <= '0; end
    else begin x1 <= dct_din; x2 <= x1; x3 <= x2; x4 <= x3; end
    if (!dct_enable_4) begin y1 <= '0; y2 <= '0; y3 <= '0; y4 <= '0; end
    else begin y1 <= dct_din_4; y2 <= y1; y3 <= y2; y4 <= y3; end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  logic [WL-1:0]  din_q[$];
  logic [WLY-1:0] res_q[$];
  int off_q[$];
  int run_q[$];
  int fd_cnt = 0, fd_off = -1, fd_fc = -1, run_start = 0, run_len = 0;
  bit en_prev = 1'b0;
  logic [WLY-1:0] res4_q[$];
  int off4_q[$];
  int run4_start = 0, fd4_off = -1;
  bit en4_prev = 1'b0;

  always @(negedge clk) begin
    if (dct_enable) begin
      din_q.push_back(dct_din);
      if (!en_prev) begin run_start = cyc_n; run_len = 0; end
      run_len++;
    end else if (en_prev) begin
      run_q.push_back(run_len);
    end
    en_prev = dct_enable;
    if (out_valid) begin res_q.push_back(out_data); off_q.push_back(cyc_n - run_start); end
    if (frame_done) begin fd_cnt++; fd_off = cyc_n - run_start; fd_fc = int'(frame_cnt); end
    if (dct_enable_4 && !en4_prev) run4_start = cyc_n;
    en4_prev = dct_enable_4;
    if (out_valid_4) begin res4_q.push_back(out_data_4); off4_q.push_back(cyc_n - run4_start); end
    if (frame_done_4) fd4_off = cyc_n - run4_start;
  end

  logic [WL-1:0]  src[$];
  logic [WL-1:0]  exp_din[$];
  logic [WLY-1:0] exp_res[$];

  // reference: each frame streams its N samples then a zero; results are full 4-sample windows only
  function automatic void model(input int nfr);
    exp_din.delete();
    exp_res.delete();
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < N; i++) exp_din.push_back(src[f*N+i]);
      exp_din.push_back('0);
      for (int j = 3; j < N; j++)
        exp_res.push_back(win_f(src[f*N+j], src[f*N+j-1], src[f*N+j-2], src[f*N+j-3]));
    end
  endfunction

  task automatic clr_mon();
    din_q.delete(); res_q.delete(); off_q.delete(); run_q.delete();
    fd_cnt = 0; fd_off = -1; fd_fc = -1;
  endtask

  task automatic drive(input int n, input bit gapped);
    int sent = 0;
    int guard = 0;
    bit gap = 1'b0;
    bit acc;
    while (sent < n && guard < 600) begin
      in_valid = !(gapped && gap);
      in_data  = src[sent];
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      gap = ~gap;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (sent != n) begin n_fail++; $display("FAIL drive_timeout: accepted %0d, required %0d", sent, n); end
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    while (fd_cnt < n && g < 400) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b1; in_data = 16'hdead;
    repeat (3) @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b, want 0", in_ready); end
    n_chk++; if (dct_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b, want 0", dct_enable); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, want 0", out_valid); end
    n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d, want 0", frame_cnt); end
    n_chk++; if (out_data !== '0 || dct_din !== '0) begin n_fail++; $display("FAIL rst_data: got %h/%h, want 0/0", out_data, dct_din); end
    n_chk++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_busy_done: got %b%b, want 00", busy, frame_done); end
    nrst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_ready: got %b, want 1", in_ready); end
    n_chk++; if (in_ready_4 !== 1'b1) begin n_fail++; $display("FAIL rst_first_ready4: got %b, want 1", in_ready_4); end
  endtask

  task automatic test_single();
    clr_mon();
    src.delete();
    for (int k = 1; k <= N; k++) src.push_back(WL'(k * 16'h0101));
    model(1);
    drive(N, 1'b0);
    wait_done(1);
    exp_frames++;
    n_chk++; if (run_q.size() != 1 || run_q[0] != N+1) begin n_fail++; $display("FAIL single_enable_len: got %0d runs first %0d, want 1 run of %0d", run_q.size(), (run_q.size() > 0) ? run_q[0] : -1, N+1); end
    n_chk++; if (din_q.size() != exp_din.size()) begin n_fail++; $display("FAIL single_din_count: got %0d, want %0d", din_q.size(), exp_din.size()); end
    for (int i = 0; i < exp_din.size() && i < din_q.size(); i++) begin
      n_chk++; if (din_q[i] !== exp_din[i]) begin n_fail++; $display("FAIL single_din[%0d]: got %h, want %h", i, din_q[i], exp_din[i]); end
    end
    n_chk++; if (res_q.size() != N-3) begin n_fail++; $display("FAIL single_res_count: got %0d, want %0d", res_q.size(), N-3); end
    for (int i = 0; i < exp_res.size() && i < res_q.size(); i++) begin
      n_chk++; if (res_q[i] !== exp_res[i]) begin n_fail++; $display("FAIL single_res[%0d]: got %h, want %h", i, res_q[i], exp_res[i]); end
      n_chk++; if (off_q[i] != 6 + i) begin n_fail++; $display("FAIL single_res_cycle[%0d]: got %0d, want %0d", i, off_q[i], 6 + i); end
    end
    n_chk++; if (fd_cnt != 1 || fd_off != N+2) begin n_fail++; $display("FAIL single_frame_done: got %0d pulses at %0d, want 1 at %0d", fd_cnt, fd_off, N+2); end
    n_chk++; if (fd_fc != exp_frames || frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL single_frame_cnt: got %0d/%0d, want %0d", fd_fc, frame_cnt, exp_frames); end
  endtask

  task automatic test_gapped();
    clr_mon();
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(WL'($urandom));
    model(1);
    drive(N, 1'b1);
    wait_done(1);
    exp_frames++;
    n_chk++; if (run_q.size() != 1 || run_q[0] != N+1) begin n_fail++; $display("FAIL gapped_enable_len: got %0d runs first %0d, want 1 run of %0d", run_q.size(), (run_q.size() > 0) ? run_q[0] : -1, N+1); end
    for (int i = 0; i < exp_din.size(); i++) begin
      n_chk++; if (i >= din_q.size() || din_q[i] !== exp_din[i]) begin n_fail++; $display("FAIL gapped_din[%0d]: got %h, want %h", i, (i < din_q.size()) ? din_q[i] : 'x, exp_din[i]); end
    end
    for (int i = 0; i < exp_res.size(); i++) begin
      n_chk++; if (i >= res_q.size() || res_q[i] !== exp_res[i]) begin n_fail++; $display("FAIL gapped_res[%0d]: got %h, want %h", i, (i < res_q.size()) ? res_q[i] : 'x, exp_res[i]); end
    end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL gapped_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    src.delete();
    for (int k = 0; k < 3*N; k++) src.push_back(WL'($urandom));
    model(3);
    drive(3*N, 1'b0);
    wait_done(3);
    exp_frames += 3;
    n_chk++; if (res_q.size() != 3*(N-3)) begin n_fail++; $display("FAIL b2b_res_count: got %0d, want %0d", res_q.size(), 3*(N-3)); end
    for (int i = 0; i < exp_res.size(); i++) begin
      n_chk++; if (i >= res_q.size() || res_q[i] !== exp_res[i]) begin n_fail++; $display("FAIL b2b_res[%0d]: got %h, want %h", i, (i < res_q.size()) ? res_q[i] : 'x, exp_res[i]); end
    end
    n_chk++; if (run_q.size() != 3) begin n_fail++; $display("FAIL b2b_runs: got %0d, want 3", run_q.size()); end
    n_chk++; if (din_q.size() != exp_din.size()) begin n_fail++; $display("FAIL b2b_din_count: got %0d, want %0d", din_q.size(), exp_din.size()); end
    n_chk++; if (fd_cnt != 3 || frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL b2b_frames: got %0d pulses cnt %0d, want 3 cnt %0d", fd_cnt, frame_cnt, exp_frames); end
  endtask

  task automatic test_soft_clr();
    clr_mon();
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(WL'($urandom));
    drive(N, 1'b0);
    repeat (4) @(negedge clk);
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr = 1'b0;
    n_chk++; if (dct_enable !== 1'b0) begin n_fail++; $display("FAIL clr_enable: got %b, want 0", dct_enable); end
    n_chk++; if (din_q.size() != 5) begin n_fail++; $display("FAIL clr_streamed: got %0d, want 5", din_q.size()); end
    n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_state: got ready %b busy %b, want 1 0", in_ready, busy); end
    repeat (20) @(negedge clk);
    n_chk++; if (res_q.size() != 0 || fd_cnt != 0) begin n_fail++; $display("FAIL clr_no_output: got %0d results %0d done, want 0 0", res_q.size(), fd_cnt); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL clr_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames); end
    clr_mon();
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(WL'($urandom));
    model(1);
    drive(N, 1'b0);
    wait_done(1);
    exp_frames++;
    n_chk++; if (res_q.size() != N-3) begin n_fail++; $display("FAIL clr_next_count: got %0d, want %0d", res_q.size(), N-3); end
    for (int i = 0; i < exp_res.size(); i++) begin
      n_chk++; if (i >= res_q.size() || res_q[i] !== exp_res[i]) begin n_fail++; $display("FAIL clr_next_res[%0d]: got %h, want %h", i, (i < res_q.size()) ? res_q[i] : 'x, exp_res[i]); end
    end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL clr_next_frame_cnt: got %0d, want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_len4();
    logic [WL-1:0] s4 [4];
    logic [WLY-1:0] want;
    int sent = 0;
    int g = 0;
    bit acc;
    for (int k = 0; k < 4; k++) s4[k] = WL'($urandom);
    want = win_f(s4[3], s4[2], s4[1], s4[0]);
    while (sent < 4 && g < 100) begin
      in_valid_4 = 1'b1;
      in_data_4  = s4[sent];
      acc = in_valid_4 && in_ready_4;
      @(posedge clk);
      if (acc) sent++;
      g++;
      @(negedge clk);
    end
    in_valid_4 = 1'b0;
    g = 0;
    while (fd4_off < 0 && g < 50) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    n_chk++; if (sent != 4) begin n_fail++; $display("FAIL len4_accept: got %0d, want 4", sent); end
    n_chk++; if (res4_q.size() != 1) begin n_fail++; $display("FAIL len4_count: got %0d, want 1", res4_q.size()); end
    n_chk++; if (res4_q.size() < 1 || res4_q[0] !== want) begin n_fail++; $display("FAIL len4_value: got %h, want %h", (res4_q.size() > 0) ? res4_q[0] : 'x, want); end
    n_chk++; if (off4_q.size() < 1 || off4_q[0] != 6) begin n_fail++; $display("FAIL len4_cycle: got %0d, want 6", (off4_q.size() > 0) ? off4_q[0] : -1); end
    n_chk++; if (fd4_off != 6 || frame_cnt_4 !== 16'd1) begin n_fail++; $display("FAIL len4_done: got at %0d cnt %0d, want at 6 cnt 1", fd4_off, frame_cnt_4); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_back_to_back();
    test_soft_clr();
    test_len4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
